cathode_top: RTL and testbench

Registered hex-to-seven-segment cathode decoder. It converts one 4-bit nibble into the 8-bit cathode pattern (seven segments plus decimal point) for a single digit. Eight instances sit inside the `seven_segment` display driver, one per digit; the anode scanner there selects which instance's output reaches the board pins.

---
 rtl/cathode_top.sv | 66 ++++++
 tb/tb_cathode_top.sv | 105 ++++++++++
 2 files changed

// File: rtl/cathode_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cathode_top
// Function : Registered hex-to-seven-segment cathode decoder (a..g, dp).
//            Optional macro CATHODE_ACTIVE_HIGH_EN inverts every output bit.
// Revision : 1.0  initial release
// ============================================================================
module cathode_top (
    input  logic       Clk,
    input  logic [3:0] encoded,
    output logic [7:0] segments,
    input  logic       Reset
);

`ifdef CATHODE_ACTIVE_HIGH_EN
    localparam logic [7:0] POLARITY_MASK = 8'hFF;
`else
    localparam logic [7:0] POLARITY_MASK = 8'h00;
`endif

    // All segments dark, decimal point included.
    localparam logic [7:0] BLANK = 8'hFF ^ POLARITY_MASK;

    logic [7:0] decoded_low;
    logic [7:0] decoded;
    // Power-up value matches the reset value so the display starts dark.
    logic [7:0] segments_q = BLANK;

    // Table is held in active-low form; unknown codes fall through to blank.
    always_comb begin
        decoded_low = 8'hFF;
        case (encoded)
            4'h0:    decoded_low = 8'hC0;
            4'h1:    decoded_low = 8'hF9;
            4'h2:    decoded_low = 8'hA4;
            4'h3:    decoded_low = 8'hB0;
            4'h4:    decoded_low = 8'h99;
            4'h5:    decoded_low = 8'h92;
            4'h6:    decoded_low = 8'h82;
            4'h7:    decoded_low = 8'hF8;
            4'h8:    decoded_low = 8'h80;
            4'h9:    decoded_low = 8'h90;
            4'hA:    decoded_low = 8'h88;
            4'hB:    decoded_low = 8'h83;
            4'hC:    decoded_low = 8'hC6;
            4'hD:    decoded_low = 8'hA1;
            4'hE:    decoded_low = 8'h86;
            4'hF:    decoded_low = 8'h8E;
            default: decoded_low = 8'hFF;
        endcase
        decoded = decoded_low ^ POLARITY_MASK;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            segments_q <= BLANK;
        end else begin
            segments_q <= decoded;
        end
    end

    assign segments = segments_q;

endmodule
`default_nettype wire

// File: tb/tb_cathode_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cathode_top
// Function : Self-checking bench for cathode_top (scoreboard of expected patterns).
// Revision : 1.0  initial release
// ============================================================================
module tb_cathode_top;

`ifdef CATHODE_ACTIVE_HIGH_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] encoded;
    logic [7:0] segments;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    cathode_top dut (
        .Clk      (clk),
        .encoded  (encoded),
        .segments (segments),
        .Reset    (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] v, input logic r);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (r || $isunknown(v)) return 8'hFF ^ INV;
        return tbl[v] ^ INV;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, compare 1 ns after the following rising edge.
    task automatic step(input string tag, input logic [3:0] v, input logic r);
        logic [7:0] exp;
        @(negedge clk);
        encoded = v;
        rst     = r;
        exp_q.push_back(model(v, r));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, segments, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        encoded = 4'h8;

        #1;
        check("power_up", segments, 8'hFF ^ INV);

        step("reset_edge1", 4'h8, 1'b1);
        step("reset_edge2", 4'h8, 1'b1);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("decode_%0h", i), 4'(i), 1'b0);
        end

        // Glitch between edges must not be captured.
        step("hold_3", 4'h3, 1'b0);
        @(negedge clk);
        encoded = 4'h5;
        #2;
        check("mid_cycle_5", segments, model(4'h3, 1'b0));
        encoded = 4'h3;
        exp_q.push_back(model(4'h3, 1'b0));
        @(posedge clk);
        #1;
        check("glitch_3", segments, exp_q.pop_front());

        step("stream_a1", 4'hA, 1'b0);
        step("stream_rst", 4'hA, 1'b1);
        step("stream_a2", 4'hA, 1'b0);

        step("unknown_in", 4'bxxxx, 1'b0);
        step("after_x_f", 4'hF, 1'b0);
        step("final_rst", 4'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
